matvec_sequencer: RTL and testbench

- Sequences one shared combinational DotProduct unit to compute y = W·x, one output element per row of an M×N weight matrix.
- Latches the input vector x on start, then streams weight rows in through a valid/ready handshake.
- Drives the DotProduct operands, captures each result, and emits y elements in row order through a valid/ready output handshake.
- Sits between the weight fetch path and the activation/writeback stage of the NPU.

---
 rtl/matvec_sequencer.sv | 157 +++++++++++++++
 tb/tb_matvec_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_sequencer.sv
// Sequences a shared combinational DotProduct unit to compute y = W*x, one element per weight row.
// Optional build macro MATVEC_RELU_EN clamps negative dot-product results to zero on capture.

module matvec_sequencer #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int M     = 4,
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x [N],
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic signed [WIDTH-1:0] w_row [N],
  output logic signed [WIDTH-1:0] dp_a [N],
  output logic signed [WIDTH-1:0] dp_b [N],
  input  logic signed [WIDTH-1:0] dp_out,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic signed [WIDTH-1:0] y_data,
  output logic [IDX_W-1:0]        y_index,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both high.
  // w_ready and y_valid are decoded from state alone, so they never depend on the
  // partner's valid/ready and are never asserted together.

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CALC = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(M - 1);

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] x_reg [N];
  logic signed [WIDTH-1:0] w_reg [N];
  logic signed [WIDTH-1:0] y_reg;
  logic [IDX_W-1:0]        row_cnt;

  logic                    x_load, w_load, y_load, cnt_clr, cnt_inc;
  logic signed [WIDTH-1:0] capture_val;

`ifdef MATVEC_RELU_EN
  always_comb begin
    capture_val = dp_out[WIDTH-1] ? '0 : dp_out;
  end
`else
  always_comb begin
    capture_val = dp_out;
  end
`endif

  always_comb begin
    state_d = state_q;
    x_load  = 1'b0;
    w_load  = 1'b0;
    y_load  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    w_ready = 1'b0;
    y_valid = 1'b0;
    done    = 1'b0;
    busy    = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_load  = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_load  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        y_load  = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        y_valid = 1'b1;
        if (y_ready) begin
          if (row_cnt == LAST_ROW) begin
            state_d = ST_DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        x_reg[i] <= '0;
        w_reg[i] <= '0;
      end
      y_reg   <= '0;
      row_cnt <= '0;
    end else begin
      if (x_load) begin
        for (int i = 0; i < N; i++) x_reg[i] <= x[i];
      end
      if (w_load) begin
        for (int i = 0; i < N; i++) w_reg[i] <= w_row[i];
      end
      if (y_load) begin
        y_reg <= capture_val;
      end
      if (cnt_clr) begin
        row_cnt <= '0;
      end else if (cnt_inc) begin
        row_cnt <= row_cnt + IDX_W'(1);
      end
    end
  end

  // Operands stay on the shared unit continuously; only CALC samples the result.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      dp_a[i] = x_reg[i];
      dp_b[i] = w_reg[i];
    end
  end

  assign y_data    = y_reg;
  assign y_index   = row_cnt;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer: M=4 instance for job/backpressure/gap/reset cases,
// plus an M=1 instance for the single-row wraparound case.

module tb_matvec_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // M=4 instance
  logic              start, w_valid, w_ready, y_valid, y_ready, busy, done;
  logic signed [7:0] x [4];
  logic signed [7:0] w_row [4];
  logic signed [7:0] dp_a [4];
  logic signed [7:0] dp_b [4];
  logic signed [7:0] dp_out;
  logic [7:0]        y_data;
  logic [1:0]        y_index;
  logic [2:0]        dbg_state;

  // M=1 instance
  logic              start1, w_valid1, w_ready1, y_valid1, y_ready1, busy1, done1;
  logic signed [7:0] x1 [4];
  logic signed [7:0] w_row1 [4];
  logic signed [7:0] dp_a1 [4];
  logic signed [7:0] dp_b1 [4];
  logic signed [7:0] dp_out1;
  logic [7:0]        y_data1;
  logic [0:0]        y_index1;
  logic [2:0]        dbg_state1;

  int n_cmp = 0;
  int n_err = 0;
  int n_rows = 0;
  int rows_before;
  int acc, acc1;

`ifdef MATVEC_RELU_EN
  localparam logic [31:0] Y1 = 32'h00;
`else
  localparam logic [31:0] Y1 = 32'hF9;
`endif

  matvec_sequencer #(.WIDTH(8), .N(4), .M(4)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .dp_a(dp_a), .dp_b(dp_b), .dp_out(dp_out),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_index(y_index),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  matvec_sequencer #(.WIDTH(8), .N(4), .M(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .x(x1),
    .w_valid(w_valid1), .w_ready(w_ready1), .w_row(w_row1),
    .dp_a(dp_a1), .dp_b(dp_b1), .dp_out(dp_out1),
    .y_valid(y_valid1), .y_ready(y_ready1), .y_data(y_data1), .y_index(y_index1),
    .busy(busy1), .done(done1), .dbg_state(dbg_state1)
  );

  // Reference combinational DotProduct units: sum of products truncated to 8 bits.
  always_comb begin
    acc = 0;
    for (int i = 0; i < 4; i++) acc = acc + int'(dp_a[i]) * int'(dp_b[i]);
    dp_out = acc[7:0];
  end

  always_comb begin
    acc1 = 0;
    for (int i = 0; i < 4; i++) acc1 = acc1 + int'(dp_a1[i]) * int'(dp_b1[i]);
    dp_out1 = acc1[7:0];
  end

  always @(posedge clk) begin
    if (w_valid && w_ready) n_rows <= n_rows + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_x_basic();
    x[0] = 8'sh03; x[1] = 8'sh01; x[2] = 8'sh01; x[3] = 8'sh02;
  endtask

  task automatic start_job();
    rows_before = n_rows;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_wready", 32'(w_ready), 32'h1);
  endtask

  // Entered at a negedge while the DUT sits in LOAD.
  task automatic run_row(input logic [31:0] row, input int gap, input int stall,
                         input logic [31:0] exp_y, input logic [31:0] exp_idx);
    w_valid = 1'b0;
    repeat (gap) begin
      tick();
      chk("gap_wready", 32'(w_ready), 32'h1);
    end
    for (int i = 0; i < 4; i++) w_row[i] = row[31-8*i -: 8];
    w_valid = 1'b1;
    y_ready = (stall == 0);
    tick();
    w_valid = 1'b0;
    chk("calc_wready", 32'(w_ready), 32'h0);
    chk("calc_yvalid", 32'(y_valid), 32'h0);
    tick();
    chk("emit_yvalid", 32'(y_valid), 32'h1);
    chk("emit_wready", 32'(w_ready), 32'h0);
    chk("emit_ydata", 32'(y_data), exp_y);
    chk("emit_yindex", 32'(y_index), exp_idx);
    chk("emit_busy", 32'(busy), 32'h1);
    if (stall > 0) begin
      for (int i = 0; i < 4; i++) w_row[i] = 8'sh55;
      w_valid = 1'b1;
      repeat (stall) begin
        tick();
        chk("stall_yvalid", 32'(y_valid), 32'h1);
        chk("stall_ydata", 32'(y_data), exp_y);
        chk("stall_yindex", 32'(y_index), exp_idx);
        chk("stall_wready", 32'(w_ready), 32'h0);
      end
      w_valid = 1'b0;
      y_ready = 1'b1;
    end
    tick();
  endtask

  task automatic finish_job(input int exp_rows);
    chk("done_pulse", 32'(done), 32'h1);
    chk("done_busy", 32'(busy), 32'h1);
    chk("done_yvalid", 32'(y_valid), 32'h0);
    tick();
    chk("after_done", 32'(done), 32'h0);
    chk("after_busy", 32'(busy), 32'h0);
    chk("rows_consumed", 32'(n_rows - rows_before), 32'(exp_rows));
  endtask

  task automatic basic_rows(input int gap, input int stall1);
    run_row(32'h03010201, gap, 0,      32'h0E, 32'h0);
    run_row(32'hFFFFFFFF, gap, stall1, Y1,     32'h1);
    run_row(32'h00000000, gap, 0,      32'h00, 32'h2);
    run_row(32'h01000000, gap, 0,      32'h03, 32'h3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; w_valid = 1'b0; y_ready = 1'b0;
    start1 = 1'b0; w_valid1 = 1'b0; y_ready1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x[i] = 8'sh00; w_row[i] = 8'sh00; x1[i] = 8'sh00; w_row1[i] = 8'sh00;
    end
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wready", 32'(w_ready), 32'h0);
    chk("rst_yvalid", 32'(y_valid), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ydata", 32'(y_data), 32'h0);
    chk("rst_yindex", 32'(y_index), 32'h0);
    chk("rst_dpa", 32'(dp_a[0]), 32'h0);
    chk("rst_dpb", 32'(dp_b[3]), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    tick();

    // Basic job
    set_x_basic();
    start_job();
    basic_rows(0, 0);
    finish_job(4);

    // Backpressure at index 1
    start_job();
    basic_rows(0, 5);
    finish_job(4);

    // Gaps before every row
    start_job();
    basic_rows(3, 0);
    finish_job(4);

    // start and x changes mid-job are ignored
    start_job();
    run_row(32'h03010201, 0, 0, 32'h0E, 32'h0);
    for (int i = 0; i < 4; i++) x[i] = 8'sh7F;
    start = 1'b1;
    chk("latched_dpa", 32'(dp_a[0]), 32'h03);
    run_row(32'hFFFFFFFF, 0, 0, Y1, 32'h1);
    run_row(32'h00000000, 0, 0, 32'h00, 32'h2);
    start = 1'b0;
    run_row(32'h01000000, 0, 0, 32'h03, 32'h3);
    finish_job(4);

    // Reset while in EMIT, then a clean restart
    set_x_basic();
    start_job();
    for (int i = 0; i < 4; i++) w_row[i] = 8'sh01;
    w_valid = 1'b1;
    y_ready = 1'b0;
    tick();
    w_valid = 1'b0;
    tick();
    chk("pre_rst_yvalid", 32'(y_valid), 32'h1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("mid_rst_yvalid", 32'(y_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_wready", 32'(w_ready), 32'h0);
    chk("mid_rst_ydata", 32'(y_data), 32'h0);
    chk("mid_rst_yindex", 32'(y_index), 32'h0);
    tick();
    start_job();
    basic_rows(0, 0);
    finish_job(4);

    // M=1 instance with a wrapping dot product
    x1[0] = 8'sh7F; x1[1] = 8'sh7F; x1[2] = 8'sh00; x1[3] = 8'sh00;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("m1_wready", 32'(w_ready1), 32'h1);
    w_row1[0] = 8'sh7F; w_row1[1] = 8'sh7F; w_row1[2] = 8'sh00; w_row1[3] = 8'sh00;
    w_valid1 = 1'b1;
    y_ready1 = 1'b1;
    tick();
    w_valid1 = 1'b0;
    tick();
    chk("m1_yvalid", 32'(y_valid1), 32'h1);
    chk("m1_ydata", 32'(y_data1), 32'h02);
    chk("m1_yindex", 32'(y_index1), 32'h0);
    tick();
    chk("m1_done", 32'(done1), 32'h1);
    chk("m1_state", 32'(dbg_state1), 32'h4);
    tick();
    chk("m1_done_end", 32'(done1), 32'h0);
    chk("m1_busy_end", 32'(busy1), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
